// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared definitions for the data-memory arbiter.
//   arb_state_e        - arbiter FSM states (ARB_ST / FORCE_EXT_ST)
//   EXT_STARVE_MAX_DEF - default number of consecutive cycles the external
//                        requester may wait before it gets a forced grant
package dm_arbiter_pkg;

  typedef enum logic {
    ARB_ST       = 1'b0,
    FORCE_EXT_ST = 1'b1
  } arb_state_e;

  localparam int unsigned EXT_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// dm_arb_starve_ctr: counts consecutive cycles in which the external request
// is pending but not granted, and flags when the arbiter must force the next
// grant to the external side.
//   clk        in  system clock, rising edge
//   reset      in  asynchronous, active-low
//   in_arb     in  arbiter is currently in ARB_ST
//   ext_valid  in  external request pending
//   ext_gnt    in  external request granted this cycle
//   force_next out next cycle must be a forced external grant
module dm_arb_starve_ctr
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned EXT_STARVE_MAX = EXT_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in_arb,
  input  logic ext_valid,
  input  logic ext_gnt,
  output logic force_next
);

  logic [7:0] starve_cnt;
  logic [8:0] cnt_inc;
  logic       waiting;

  // Force is decided on the value the counter would take this edge, so the
  // forced grant lands exactly EXT_STARVE_MAX waiting cycles later.
  always_comb begin
    waiting    = ext_valid & ~ext_gnt;
    cnt_inc    = {1'b0, starve_cnt} + 9'd1;
    force_next = in_arb & waiting & (cnt_inc == 9'(EXT_STARVE_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (waiting) begin
      starve_cnt <= cnt_inc[7:0];
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates the single-port data memory between the pipeline
// M stage (CPU) and an external requester (loader / debug bridge).
// The CPU normally wins; after EXT_STARVE_MAX consecutive lost cycles the
// external side gets one forced grant and the CPU is stalled for that cycle.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_pc/cpu_addr/cpu_wd  CPU request; cpu_rd load data
//   cpu_stall                              CPU request not granted this cycle
//   ext_valid/ext_we/ext_addr/ext_wd       external request; ext_ready = grant
//   ext_rvalid/ext_rdata                   registered read return
//   mem_we/mem_pc/mem_addr/mem_wd, mem_rd  data-memory port
// Optional: define DM_ARB_TRACE_EN to print one line per memory write.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned EXT_STARVE_MAX = EXT_STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        ext_valid,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wd,
  output logic        ext_ready,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  arb_state_e state, next_state;
  logic       cpu_gnt, ext_gnt;
  logic       force_next;

  dm_arb_starve_ctr #(
    .EXT_STARVE_MAX(EXT_STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .in_arb    (state == ARB_ST),
    .ext_valid (ext_valid),
    .ext_gnt   (ext_gnt),
    .force_next(force_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_ST;
    end else begin
      state <= next_state;
    end
  end

  // Grant is kept separate from next-state so force_next (which depends on
  // ext_gnt) does not feed back into the block that produces ext_gnt.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    case (state)
      ARB_ST: begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_valid & ~cpu_req;
      end
      FORCE_EXT_ST: begin
        ext_gnt = ext_valid;
        cpu_gnt = cpu_req & ~ext_valid;
      end
      default: begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
      end
    endcase
  end

  always_comb begin
    next_state = ARB_ST;
    case (state)
      ARB_ST:       next_state = force_next ? FORCE_EXT_ST : ARB_ST;
      FORCE_EXT_ST: next_state = ARB_ST;
      default:      next_state = ARB_ST;
    endcase
  end

  always_comb begin
    ext_ready = ext_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_we    = 1'b0;
    mem_pc    = '0;
    mem_addr  = '0;
    mem_wd    = '0;
    cpu_rd    = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_pc   = cpu_pc;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      cpu_rd   = mem_rd;
    end else if (ext_gnt) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else if (ext_gnt && !ext_we) begin
      ext_rvalid <= 1'b1;
      ext_rdata  <= mem_rd;
    end else begin
      ext_rvalid <= 1'b0;
    end
  end

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      $display("%d@%h: *%h <= %h", $time, mem_pc, mem_addr, mem_wd);
    end
  end
`endif

endmodule
